i2s_rx: RTL and testbench
=========================

// Module: i2s_rx
// PURPOSE
//   Receives a serial I2S stereo stream and converts it to parallel words. It is the
//   receiving end of the serial audio link, the counterpart of the 16-bit serializer.
//   SCK, WS and SD are sampled in the system clock domain.
//   Outputs one left/right sample pair per frame, with a one-cycle valid strobe.
// PARAMETERS
//   WIDTH  16  bits per channel word; MSB first; word sits in the SD slot
// PORTS
//   clk      in   1      system clock; must run at least 4x the SCK frequency
//   rst_n    in   1      synchronous, active-low reset
//   sck      in   1      I2S bit clock; asynchronous to clk
//   ws       in   1      word select: 0 = left, 1 = right; asynchronous to clk
//   sd       in   1      serial data; asynchronous to clk
//   l_data   out  WIDTH  last completed left word
//   r_data   out  WIDTH  last completed right word
//   valid    out  1      1-clk pulse: l_data/r_data now hold a complete frame
//   frame_err out 1      1-clk pulse: the word just closed had a bit count != WIDTH
// BEHAVIOUR
//   - Reset (rst_n=0 at a clk edge): clear all state in the same cycle.
//     l_data=0, r_data=0, valid=0, frame_err=0, shift reg=0, bit index=0, synced=0.
//   - Input path: sck, ws and sd each pass through a 2-FF synchronizer.
//     Bit strobe = synced sck is 1 now and was 0 one clk earlier (SCK rising edge).
//     Strobe latency: 3 clk after the raw SCK edge.
//   - ws_q holds the WS value sampled at the previous strobe. The first bit of each
//     word is sampled on the strobe after the one where WS changed.
//   - Only strobe cycles act; other cycles hold all state.
//   - Each strobe with no WS change (ws_s == ws_q):
//     - if idx < WIDTH: shreg[WIDTH-1-idx] <= sd_s.
//     - idx <= min(idx+1, WIDTH+1). idx saturates at WIDTH+1, which marks overlength.
//   - Each strobe with a WS change (ws_s != ws_q): this is the LSB strobe of the ws_q word.
//     - word = shreg with sd_s inserted at bit WIDTH-1-idx if idx < WIDTH.
//     - Overlength words keep their first WIDTH bits (MSB-aligned).
//     - Short words are left-aligned, with the missing LSBs zero.
//     - If synced=1: store word in l_data when ws_q=0, or in r_data when ws_q=1.
//     - If synced=1 and ws_q=1: pulse valid on the next clk.
//     - If synced=1 and idx+1 != WIDTH: pulse frame_err on the next clk.
//     - Always: shreg <= 0, idx <= 0, synced <= 1, ws_q <= ws_s.
//   - The first partial word after reset is discarded: synced=0, no store, no flags.
//   - valid and frame_err assert on the same clk, aligned with the data update.
//     Both stay high for exactly 1 clk.
//   - l_data and r_data change only on a store and are stable in between.
//   - A reset mid-word drops the partial word. Reception resumes at the next WS edge.
//   - SCK faster than clk/4 is out of spec and its behaviour is undefined.
//   - SD is sampled at SCK rising edges; the transmitter changes SD and WS on falling edges.
// TESTING
//   1 Reset: hold rst_n=0 for 2 clk while toggling inputs
//     -> l_data=0, r_data=0, valid=0, frame_err=0.
//   2 Frame: L=16'hA5C3, R=16'h1234, clk = 8x SCK, after one sync frame
//     -> single valid, l_data=A5C3, r_data=1234, frame_err=0.
//   3 Back-to-back: 4 frames with L/R = 0001/8000, FFFF/0000, 7FFF/8001, 0F0F/F0F0
//     -> 4 valid pulses, each word exact, no gaps.
//   4 Overlength: 18-bit slots, L=18'h2A5C3, R=18'h3FFFC
//     -> l_data=A970, r_data=FFFF, frame_err pulses twice.
//   5 Short: 14-bit slots, L=14'h1234
//     -> l_data=48D0, frame_err pulses.
//   6 Reset mid-word: assert rst_n=0 at bit 7 of L, release, send a full frame
//     -> no valid until the first full L/R frame after a WS edge; then correct data.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S stereo receiver: synchronizes SCK/WS/SD into the clk domain and assembles
// MSB-first words into left/right parallel outputs with per-frame valid/error strobes.
module i2s_rx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sck,
  input  logic             ws,
  input  logic             sd,
  output logic [WIDTH-1:0] l_data,
  output logic [WIDTH-1:0] r_data,
  output logic             valid,
  output logic             frame_err
);

  localparam int IDXW = $clog2(WIDTH + 2);
  localparam int POSW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] C_WIDTH   = IDXW'(WIDTH);
  localparam logic [IDXW-1:0] C_LAST    = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0] C_IDX_MAX = IDXW'(WIDTH + 1);

  logic             r_sck_meta, r_sck_sync, r_sck_prev;
  logic             r_ws_meta, r_ws_sync;
  logic             r_sd_meta, r_sd_sync;
  logic             r_ws_q;
  logic [WIDTH-1:0] r_shreg;
  logic [IDXW-1:0]  r_idx;
  logic             r_synced;
  logic [WIDTH-1:0] r_l_data, r_r_data;
  logic             r_valid, r_frame_err;

  logic             w_strobe;
  logic             w_ws_change;
  logic             w_in_range;
  logic [POSW-1:0]  w_pos;
  logic [WIDTH-1:0] w_word;

  assign w_strobe    = r_sck_sync & ~r_sck_prev;
  assign w_ws_change = r_ws_sync ^ r_ws_q;
  assign w_in_range  = (r_idx < C_WIDTH);
  assign w_pos       = POSW'(C_LAST - r_idx);

  // Shift register contents with the current SD bit merged in at the running index.
  always_comb begin
    w_word = r_shreg;
    if (w_in_range) begin
      w_word[w_pos] = r_sd_sync;
    end else begin
      w_word = r_shreg;
    end
  end

  // Synchronizers, word assembly and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sck_meta  <= 1'b0;
      r_sck_sync  <= 1'b0;
      r_sck_prev  <= 1'b0;
      r_ws_meta   <= 1'b0;
      r_ws_sync   <= 1'b0;
      r_sd_meta   <= 1'b0;
      r_sd_sync   <= 1'b0;
      r_ws_q      <= 1'b0;
      r_shreg     <= '0;
      r_idx       <= '0;
      r_synced    <= 1'b0;
      r_l_data    <= '0;
      r_r_data    <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sck_meta  <= sck;
      r_sck_sync  <= r_sck_meta;
      r_sck_prev  <= r_sck_sync;
      r_ws_meta   <= ws;
      r_ws_sync   <= r_ws_meta;
      r_sd_meta   <= sd;
      r_sd_sync   <= r_sd_meta;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_strobe) begin
        if (!w_ws_change) begin
          r_shreg <= w_word;
          if (r_idx != C_IDX_MAX) begin
            r_idx <= r_idx + IDXW'(1);
          end else begin
            r_idx <= r_idx;
          end
        end else begin
          // This strobe carries the LSB of the word that belonged to r_ws_q.
          if (r_synced) begin
            if (r_ws_q) begin
              r_r_data <= w_word;
            end else begin
              r_l_data <= w_word;
            end
            r_valid     <= r_ws_q;
            r_frame_err <= (r_idx != C_LAST);
          end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
          end
          r_shreg  <= '0;
          r_idx    <= '0;
          r_synced <= 1'b1;
          r_ws_q   <= r_ws_sync;
        end
      end else begin
        r_shreg <= r_shreg;
        r_idx   <= r_idx;
      end
    end
  end

  assign l_data    = r_l_data;
  assign r_data    = r_r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: drives an I2S transmitter at clk/8 and compares
// captured frames against a word-level model of the receiver.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        ws = 1'b0;
  logic        sd = 1'b0;
  logic [15:0] l_data, r_data;
  logic        valid, frame_err;

  always #5 clk = ~clk;

  i2s_rx #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ws(ws), .sd(sd),
    .l_data(l_data), .r_data(r_data), .valid(valid), .frame_err(frame_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Monitor: records every valid pulse and counts frame_err pulses.
  logic [31:0] got_q[$];
  int          got_cyc[$];
  int          fe_seen = 0;
  int          dbl_seen = 0;
  int          cyc = 0;
  logic        prev_v = 1'b0;
  logic        prev_fe = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (valid === 1'b1) begin
      got_q.push_back({l_data, r_data});
      got_cyc.push_back(cyc);
    end
    if (frame_err === 1'b1) fe_seen++;
    if ((valid === 1'b1 && prev_v === 1'b1) || (frame_err === 1'b1 && prev_fe === 1'b1)) dbl_seen++;
    prev_v  = valid;
    prev_fe = frame_err;
  end

  // Word-level reference model.
  logic [31:0] exp_q[$];
  int          exp_fe = 0;
  bit          m_synced = 1'b0;
  logic [15:0] m_l = 16'h0000;

  function automatic logic [15:0] align(input logic [31:0] v, input int n);
    if (n >= 16) return 16'(v >> (n - 16));
    else return 16'(v << (16 - n));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input bit ch, input int n, input logic [31:0] v, input bit nxt);
    for (int i = n - 1; i >= 0; i--) begin
      ws = (i == 0) ? nxt : ch;
      sd = v[i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
    if (m_synced) begin
      if (!ch) m_l = align(v, n);
      else exp_q.push_back({m_l, align(v, n)});
      if (n != 16) exp_fe++;
    end
    m_synced = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] lv, input int nl, input logic [31:0] rv, input int nr);
    send_word(1'b0, nl, lv, 1'b1);
    send_word(1'b1, nr, rv, 1'b0);
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    #2;
  endtask

  task automatic clear_all();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    fe_seen = 0; exp_fe = 0; dbl_seen = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    m_synced = 1'b0;
    m_l = 16'h0000;
  endtask

  task automatic check_burst(input string tag, input bit gaps);
    int n;
    settle();
    chk({tag, " nvalid"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, " frame"}, got_q[i], exp_q[i]);
    chk({tag, " frame_err"}, 32'(fe_seen), 32'(exp_fe));
    chk({tag, " pulse_width"}, 32'(dbl_seen), 32'd0);
    if (gaps) begin
      for (int i = 1; i < got_cyc.size(); i++)
        chk({tag, " gap"}, 32'(got_cyc[i] - got_cyc[i-1]), 32'd256);
    end
    clear_all();
  endtask

  function automatic logic [31:0] rnd(input int n);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    return $urandom() & mask;
  endfunction

  initial begin
    int nl, nr;
    // 1: reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      #5 sck = ~sck; ws = ~ws; sd = ~sd;
    end
    sck = 1'b0; ws = 1'b0; sd = 1'b0;
    @(negedge clk);
    chk("rst l_data", 32'(l_data), 32'd0);
    chk("rst r_data", 32'(r_data), 32'd0);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst frame_err", 32'(frame_err), 32'd0);
    do_reset();
    clear_all();

    // 2: sync frame, then a single known frame
    send_frame(rnd(16), 16, rnd(16), 16);
    check_burst("sync", 1'b0);
    send_frame(32'h0000A5C3, 16, 32'h00001234, 16);
    check_burst("frame", 1'b0);
    chk("frame l_data", 32'(l_data), 32'h0000A5C3);
    chk("frame r_data", 32'(r_data), 32'h00001234);

    // 3: back-to-back frames
    send_frame(32'h0001, 16, 32'h8000, 16);
    send_frame(32'hFFFF, 16, 32'h0000, 16);
    send_frame(32'h7FFF, 16, 32'h8001, 16);
    send_frame(32'h0F0F, 16, 32'hF0F0, 16);
    check_burst("b2b", 1'b1);

    // 4: overlength slots
    send_frame(32'h0002A5C3, 18, 32'h0003FFFC, 18);
    chk("over fe_count", 32'(exp_fe), 32'd2);
    check_burst("over", 1'b0);
    chk("over l_data", 32'(l_data), 32'h0000A970);
    chk("over r_data", 32'(r_data), 32'h0000FFFF);

    // 5: short slots
    send_frame(32'h00001234, 14, rnd(14), 14);
    check_burst("short", 1'b0);
    chk("short l_data", 32'(l_data), 32'h000048D0);

    // 6: reset in the middle of a left word
    for (int i = 15; i >= 7; i--) begin
      ws = 1'b0; sd = $urandom_range(1, 0);
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
    do_reset();
    settle();
    chk("midrst l_data", 32'(l_data), 32'd0);
    chk("midrst r_data", 32'(r_data), 32'd0);
    clear_all();
    send_frame(rnd(16), 16, rnd(16), 16);
    send_frame(rnd(16), 16, rnd(16), 16);
    if (got_q.size() > 0) chk("midrst first l", 32'(got_q[0][31:16]), 32'd0);
    check_burst("midrst", 1'b0);

    // Randomized frames with mixed slot lengths
    for (int f = 0; f < 8; f++) begin
      nl = $urandom_range(18, 14);
      nr = $urandom_range(18, 14);
      send_frame(rnd(nl), nl, rnd(nr), nr);
    end
    check_burst("random", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
